i2c_reg_reader_100khz: RTL and testbench

//  Consumes the 100 kHz tick clock from the 1 MHz->100 kHz divider and runs single-master
//  I2C register reads of the avionics sensors (baro/IMU). A 1-cycle START request triggers:

---
 rtl/i2c_reg_reader_100khz.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_reg_reader_100khz.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_reader_100khz.sv
`timescale 1ns/1ps
// i2c_reg_reader_100khz
//   Single-master I2C register reader clocked by the 100 kHz tick clock.
//   A one-cycle START request in IDLE runs the following bus sequence:
//   START, addr+W, reg, repeated START, addr+R, N data bytes, STOP.
//   Each bus slot is 4 clocks, so SCL runs at 25 kHz.
//   No clock stretching and no arbitration.
// Ports
//   CLK_100KHZ_IN  clock; all logic runs on its rising edge
//   RESET          asynchronous, active-low reset
//   START          one-cycle transfer request, honoured only in IDLE
//   REG_ADDR       sensor register address, latched when START is accepted
//   NUM_BYTES      read length; 0 reads 1 byte, values above MAX_BYTES are clamped
//   SDA_IN         SDA pad level
//   SCL_OUT        SCL level (1 = released)
//   SDA_OE         1 = pull SDA low, 0 = release it
//   BUSY           high from the cycle after an accepted START through the last STOP cycle
//   DATA_OUT       read result, right-justified, first byte most significant
//   DATA_VALID     one-cycle pulse when a transfer completes successfully
//   ACK_ERR        sticky flag: the slave NACKed an address or register byte
module i2c_reg_reader_100khz #(
  parameter logic [6:0] DEV_ADDR  = 7'h77,
  parameter int         MAX_BYTES = 3
) (
  input  logic                   CLK_100KHZ_IN,
  input  logic                   RESET,
  input  logic                   START,
  input  logic [7:0]             REG_ADDR,
  input  logic [1:0]             NUM_BYTES,
  input  logic                   SDA_IN,
  output logic                   SCL_OUT,
  output logic                   SDA_OE,
  output logic                   BUSY,
  output logic [8*MAX_BYTES-1:0] DATA_OUT,
  output logic                   DATA_VALID,
  output logic                   ACK_ERR
);

  localparam int         DW      = 8 * MAX_BYTES;
  localparam logic [1:0] MAX_NUM = 2'(MAX_BYTES);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK1, S_REG, S_ACK2, S_RSTART,
    S_ADDR_R, S_ACK3, S_RD, S_MACK, S_STOP, S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      phase_reg;
  logic [2:0]      bit_cnt_reg;
  logic [1:0]      byte_cnt_reg;
  logic [1:0]      num_reg;
  logic [7:0]      reg_addr_reg;
  logic [7:0]      rx_reg;
  logic            sda_smp_reg;
  logic [DW-1:0]   data_out_reg;
  logic            ack_err_reg;

  logic            in_slot, slot_end, byte_end, last_byte, start_ok;
  logic            shift_state, ack_state;
  logic            scl_level, sda_drive;
  logic [7:0]      tx_byte;
  logic            tx_bit;
  logic [1:0]      num_clamped;
  logic [7:0]      rx_next;
  logic [DW+7:0]   data_cat;

  assign in_slot     = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign slot_end    = (phase_reg == 2'd3);
  assign byte_end    = slot_end && (bit_cnt_reg == 3'd7);
  // byte_cnt_reg already counts the byte just received when MACK is reached
  assign last_byte   = (byte_cnt_reg == num_reg);
  assign start_ok    = (state_reg == S_IDLE) && START;
  assign shift_state = (state_reg == S_ADDR_W) || (state_reg == S_REG) ||
                       (state_reg == S_ADDR_R) || (state_reg == S_RD);
  assign ack_state   = (state_reg == S_ACK1) || (state_reg == S_ACK2) ||
                       (state_reg == S_ACK3);
  assign rx_next     = {rx_reg[6:0], sda_smp_reg};
  assign data_cat    = {data_out_reg, rx_next};

  always_comb begin
    num_clamped = NUM_BYTES;
    if (NUM_BYTES == 2'd0)
      num_clamped = 2'd1;
    else if (NUM_BYTES > MAX_NUM)
      num_clamped = MAX_NUM;
  end

  always_comb begin
    tx_byte = 8'hFF;
    case (state_reg)
      S_ADDR_W: tx_byte = {DEV_ADDR, 1'b0};
      S_REG:    tx_byte = reg_addr_reg;
      S_ADDR_R: tx_byte = {DEV_ADDR, 1'b1};
      default:  tx_byte = 8'hFF;
    endcase
  end

  // Bytes go out MSB first
  assign tx_bit = tx_byte[3'd7 - bit_cnt_reg];

  // Next-state and bus levels; SDA only moves in p0 (SCL low) except the
  // deliberate START / repeated START / STOP edges.
  always_comb begin
    state_next = state_reg;
    scl_level  = 1'b1;
    sda_drive  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (START) state_next = S_START;
      end
      S_START: begin
        scl_level = (phase_reg < 2'd2);
        sda_drive = (phase_reg != 2'd0);
        if (slot_end) state_next = S_ADDR_W;
      end
      S_ADDR_W, S_REG, S_ADDR_R: begin
        scl_level = (phase_reg == 2'd1) || (phase_reg == 2'd2);
        sda_drive = ~tx_bit;
        if (byte_end) begin
          if (state_reg == S_ADDR_W)   state_next = S_ACK1;
          else if (state_reg == S_REG) state_next = S_ACK2;
          else                         state_next = S_ACK3;
        end
      end
      S_ACK1, S_ACK2, S_ACK3: begin
        scl_level = (phase_reg == 2'd1) || (phase_reg == 2'd2);
        if (slot_end) begin
          if (sda_smp_reg)              state_next = S_STOP;
          else if (state_reg == S_ACK1) state_next = S_REG;
          else if (state_reg == S_ACK2) state_next = S_RSTART;
          else                          state_next = S_RD;
        end
      end
      S_RSTART: begin
        scl_level = (phase_reg == 2'd1) || (phase_reg == 2'd2);
        sda_drive = (phase_reg >= 2'd2);
        if (slot_end) state_next = S_ADDR_R;
      end
      S_RD: begin
        scl_level = (phase_reg == 2'd1) || (phase_reg == 2'd2);
        if (byte_end) state_next = S_MACK;
      end
      S_MACK: begin
        scl_level = (phase_reg == 2'd1) || (phase_reg == 2'd2);
        sda_drive = ~last_byte;          // NACK the final byte
        if (slot_end) state_next = last_byte ? S_STOP : S_RD;
      end
      S_STOP: begin
        scl_level = (phase_reg != 2'd0);
        sda_drive = (phase_reg < 2'd2);
        // an address/register NACK ends without a completion pulse
        if (slot_end) state_next = ack_err_reg ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100KHZ_IN or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= S_IDLE;
      phase_reg    <= 2'd0;
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= 2'd0;
      num_reg      <= 2'd0;
      reg_addr_reg <= 8'd0;
      rx_reg       <= 8'd0;
      sda_smp_reg  <= 1'b0;
      data_out_reg <= '0;
      ack_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      // phase wraps 3 -> 0 at every slot boundary, so it stays aligned
      // across state changes without an explicit clear
      phase_reg <= in_slot ? phase_reg + 2'd1 : 2'd0;
      if (phase_reg == 2'd2)
        sda_smp_reg <= SDA_IN;
      if (shift_state && slot_end)
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      if ((state_reg == S_RD) && slot_end) begin
        rx_reg <= rx_next;
        if (bit_cnt_reg == 3'd7) begin
          data_out_reg <= data_cat[DW-1:0];
          byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
      end
      if (ack_state && slot_end && sda_smp_reg)
        ack_err_reg <= 1'b1;
      if (start_ok) begin
        reg_addr_reg <= REG_ADDR;
        num_reg      <= num_clamped;
        bit_cnt_reg  <= 3'd0;
        byte_cnt_reg <= 2'd0;
        data_out_reg <= '0;
        ack_err_reg  <= 1'b0;
      end
    end
  end

  assign SCL_OUT    = scl_level;
  assign SDA_OE     = sda_drive;
  assign BUSY       = in_slot;
  assign DATA_OUT   = data_out_reg;
  assign DATA_VALID = (state_reg == S_DONE);
  assign ACK_ERR    = ack_err_reg;

endmodule

// File: tb/tb_i2c_reg_reader_100khz.sv
`timescale 1ns/1ps
// Bench for i2c_reg_reader_100khz: bus-level slave at 0x77, a transfer-level
// timing model checked every cycle, and directed transfers with literal results.
module tb_i2c_reg_reader_100khz;

  logic        clk = 1'b0;
  logic        rst_n, start, sda_in, scl_out, sda_oe, busy, data_valid, ack_err;
  logic [7:0]  reg_addr;
  logic [1:0]  num_bytes;
  logic [23:0] data_out;

  logic        slave_pull = 1'b0;
  logic        slave_en   = 1'b1;
  logic [7:0]  rd_data [0:2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sda_in = ~(sda_oe | slave_pull);   // open-drain line with pull-up

  i2c_reg_reader_100khz dut (
    .CLK_100KHZ_IN(clk),
    .RESET(rst_n),
    .START(start),
    .REG_ADDR(reg_addr),
    .NUM_BYTES(num_bytes),
    .SDA_IN(sda_in),
    .SCL_OUT(scl_out),
    .SDA_OE(sda_oe),
    .BUSY(busy),
    .DATA_OUT(data_out),
    .DATA_VALID(data_valid),
    .ACK_ERR(ack_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- bus monitor + slave ----------------
  logic [7:0] bus_bytes [$];
  logic       macks [$];
  int         num_starts = 0, num_stops = 0;

  initial begin
    logic scl_p, sda_p, rst_p, scl_now, sda_now;
    logic [7:0] shreg, tx;
    bit   started, first, reading, is_addr, tx_on, mack_v;
    int   bitn, rd_idx;
    scl_p = 1'b1; sda_p = 1'b1; rst_p = 1'b0;
    shreg = 8'd0; tx = 8'd0;
    started = 0; first = 0; reading = 0; is_addr = 0; tx_on = 0; mack_v = 1;
    bitn = 0; rd_idx = 0;
    forever begin
      @(negedge clk);
      scl_now = scl_out;
      sda_now = sda_in;
      if (!rst_n) begin
        started = 0; tx_on = 0; reading = 0; bitn = 0; rd_idx = 0;
        slave_pull = 1'b0;
      end else begin
        if (rst_p)
          chk("proto_sda_scl_same_cycle", {31'd0, (scl_now != scl_p) && (sda_now != sda_p)}, 32'd0);
        if (scl_now && scl_p && sda_p && !sda_now) begin
          num_starts++;
          started = 1; bitn = 0; first = 1; tx_on = 0; slave_pull = 1'b0;
        end else if (scl_now && scl_p && !sda_p && sda_now) begin
          num_stops++;
          started = 0; rd_idx = 0; tx_on = 0; reading = 0; slave_pull = 1'b0;
        end else if (started && scl_now && !scl_p) begin
          if (bitn < 8) shreg = {shreg[6:0], sda_now};
          else if (bitn == 8 && reading && !is_addr) begin
            mack_v = sda_now;
            macks.push_back(sda_now);
          end
          bitn++;
        end else if (started && !scl_now && scl_p) begin
          if (bitn == 8) begin
            bus_bytes.push_back(shreg);
            tx_on = 0;
            if (first) begin
              first = 0; is_addr = 1; reading = shreg[0];
              slave_pull = slave_en && (shreg[7:1] == 7'h77);
            end else begin
              is_addr = 0;
              slave_pull = slave_en && !reading;
            end
          end else if (bitn == 9) begin
            bitn = 0;
            if (slave_en && reading && (is_addr || mack_v == 1'b0)) begin
              tx = (rd_idx < 3) ? rd_data[rd_idx] : 8'hFF;
              rd_idx++;
              slave_pull = ~tx[7];
              tx_on = 1;
            end else begin
              slave_pull = 1'b0;
              tx_on = 0;
            end
          end else if (bitn >= 1 && bitn <= 7 && tx_on) begin
            slave_pull = ~tx[7 - bitn];
          end
        end
      end
      scl_p = scl_now; sda_p = sda_now; rst_p = rst_n;
    end
  end

  // ---------------- transfer-level model ----------------
  // A transfer accepted at edge t0 keeps BUSY high after edges t0..t0+len-1;
  // len = 4*(30+9N) clocks, or 44 when the address byte is NACKed.
  int          m_cyc = 0, m_t0 = 0, m_len = 0;
  bit          m_has = 0, m_ok = 0, m_err = 0;
  logic [23:0] m_data = 24'd0;
  int          valid_cnt = 0;

  initial begin
    int e, n;
    bit busy_b, done_b;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_cyc = 0; m_has = 0; m_ok = 0; m_err = 0; m_data = 24'd0; m_len = 0; m_t0 = 0;
      end else begin
        e = m_cyc + 1;
        busy_b = m_has && (e - 1 >= m_t0) && (e - 1 < m_t0 + m_len);
        done_b = m_has && m_ok && (e - 1 == m_t0 + m_len);
        if (start && !busy_b && !done_b) begin
          n = (num_bytes == 2'd0) ? 1 : int'(num_bytes);
          m_has = 1; m_t0 = e; m_ok = slave_en; m_err = !slave_en;
          m_len = slave_en ? 4 * (30 + 9 * n) : 44;
          m_data = 24'd0;
          if (slave_en)
            for (int i = 0; i < n; i++) m_data = {m_data[15:0], rd_data[i]};
        end
        m_cyc = e;
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    bit exp_busy, exp_valid;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_busy  = m_has && (m_cyc >= m_t0) && (m_cyc < m_t0 + m_len);
        exp_valid = m_has && m_ok && (m_cyc == m_t0 + m_len);
        chk("model_busy", {31'd0, busy}, {31'd0, exp_busy});
        chk("model_valid", {31'd0, data_valid}, {31'd0, exp_valid});
        if (!exp_busy) begin
          chk("model_data_out", {8'd0, data_out}, {8'd0, m_data});
          chk("model_ack_err", {31'd0, ack_err}, {31'd0, m_err});
        end
        if (data_valid) valid_cnt++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer(input logic [7:0] ra, input logic [1:0] nb, input bit en,
                      input int exp_clks, input logic [23:0] exp_data, input bit exp_ok,
                      input int extra_at, output int b0, output int k0);
    int n, s0, p0, v0;
    @(negedge clk);
    reg_addr = ra; num_bytes = nb; slave_en = en; start = 1'b1;
    s0 = num_starts; p0 = num_stops; v0 = valid_cnt;
    b0 = bus_bytes.size(); k0 = macks.size();
    @(negedge clk);
    start = 1'b0;
    n = 0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("ack_err_cleared_on_start", {31'd0, ack_err}, 32'd0);
    chk("data_cleared_on_start", {8'd0, data_out}, 32'd0);
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
      start = (n == extra_at);
    end
    start = 1'b0;
    $display("xfer reg=%0h num=%0d slave=%0d: %0d clks data=%06h valid=%0d ack_err=%0d",
             ra, nb, en, n, data_out, data_valid, ack_err);
    chk("xfer_clks", n, exp_clks);
    chk("valid_at_end", {31'd0, data_valid}, {31'd0, exp_ok});
    chk("data_out", {8'd0, data_out}, {8'd0, exp_data});
    chk("ack_err", {31'd0, ack_err}, {31'd0, !exp_ok});
    repeat (4) @(negedge clk);
    chk("valid_pulses", valid_cnt - v0, exp_ok ? 32'd1 : 32'd0);
    chk("start_conditions", num_starts - s0, exp_ok ? 32'd2 : 32'd1);
    chk("stop_conditions", num_stops - p0, 32'd1);
    chk("bus_idle", {30'd0, scl_out, sda_oe}, 32'd2);
  endtask

  initial begin
    int b0, k0;
    rst_n = 1'b0; start = 1'b0; reg_addr = 8'd0; num_bytes = 2'd0;
    rd_data[0] = 8'hAB; rd_data[1] = 8'hCD; rd_data[2] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'd0, scl_out}, 32'd1);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_data", {8'd0, data_out}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two-byte read of register F6
    xfer(8'hF6, 2'd2, 1'b1, 192, 24'h00ABCD, 1'b1, -1, b0, k0);
    if (bus_bytes.size() >= b0 + 5) begin
      chk("bus_addr_w", {24'd0, bus_bytes[b0]},     32'hEE);
      chk("bus_reg",    {24'd0, bus_bytes[b0 + 1]}, 32'hF6);
      chk("bus_addr_r", {24'd0, bus_bytes[b0 + 2]}, 32'hEF);
      chk("bus_data0",  {24'd0, bus_bytes[b0 + 3]}, 32'hAB);
      chk("bus_data1",  {24'd0, bus_bytes[b0 + 4]}, 32'hCD);
    end else chk("bus_byte_count", bus_bytes.size() - b0, 32'd5);
    if (macks.size() >= k0 + 2) begin
      chk("mack_byte1", {31'd0, macks[k0]},     32'd0);
      chk("mack_byte2", {31'd0, macks[k0 + 1]}, 32'd1);
    end else chk("mack_count", macks.size() - k0, 32'd2);

    // 2: NUM=0 reads one byte, NUM=3 reads three
    rd_data[0] = 8'h12; rd_data[1] = 8'h34; rd_data[2] = 8'h56;
    xfer(8'hF6, 2'd0, 1'b1, 156, 24'h000012, 1'b1, -1, b0, k0);
    xfer(8'hF6, 2'd3, 1'b1, 228, 24'h123456, 1'b1, -1, b0, k0);

    // 3: no slave -> NACK on address, then a good transfer clears ACK_ERR
    xfer(8'hF6, 2'd2, 1'b0, 44, 24'h000000, 1'b0, -1, b0, k0);
    xfer(8'h10, 2'd1, 1'b1, 156, 24'h000012, 1'b1, -1, b0, k0);

    // 4: START pulsed mid-transfer is ignored
    xfer(8'hF6, 2'd2, 1'b1, 192, 24'h001234, 1'b1, 50, b0, k0);

    // 5: reset during addr+R byte
    @(negedge clk);
    reg_addr = 8'hF6; num_bytes = 2'd1; slave_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (89) @(negedge clk);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("abort: scl=%0d sda_oe=%0d busy=%0d valid=%0d", scl_out, sda_oe, busy, data_valid);
    chk("abort_scl", {31'd0, scl_out}, 32'd1);
    chk("abort_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, data_valid}, 32'd0);
    chk("abort_ack_err", {31'd0, ack_err}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(8'hF6, 2'd3, 1'b1, 228, 24'h123456, 1'b1, -1, b0, k0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
